// File: rtl/decouple_pkg.sv
// Shared helpers for the decouple_level buffer: width calculators and the
// wrap-aware pointer increment used by both FIFO pointers.
package decouple_pkg;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry buffer still gets a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Increment with an explicit wrap at depth-1 so any depth works.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dti.sv
// Data/valid/ready channel. The producer drives data and valid, the
// consumer drives ready; a transfer happens on a clock edge where both
// valid and ready are high.
interface dti #(
  parameter int W = 16
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/decouple_ptr.sv
// Wrapping FIFO pointer: advances on inc, returns to zero on clr (clr wins),
// and comes out of reset at RST_VAL.
module decouple_ptr
  import decouple_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  input  logic                      clr,
  output logic [ptr_w(DEPTH)-1:0]   ptr
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer value: clear has priority over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = PW'(ptr_next(32'(ptr_q), DEPTH));
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PW'(RST_VAL);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/decouple_level.sv
// Fully registered decoupling FIFO of arbitrary depth with occupancy level,
// almost-full/almost-empty flags, synchronous flush and optional preload of
// one item out of reset. Output data/valid and input ready come only from
// registers (plus flush), so there is no combinational path across the buffer.
module decouple_level
  import decouple_pkg::*;
#(
  parameter int             DEPTH      = 4,
  parameter int             DIN        = 16,
  parameter logic [DIN-1:0] INIT       = '0,
  parameter bit             INIT_VALID = 1'b0,
  parameter int             AFULL      = DEPTH - 1,
  parameter int             AEMPTY     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  dti.consumer                     din,
  dti.producer                     dout,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int LW     = lvl_w(DEPTH);
  localparam int PW     = ptr_w(DEPTH);
  // With a preloaded item the write pointer starts one slot ahead.
  localparam int WR_RST = (INIT_VALID && DEPTH > 1) ? 1 : 0;

  logic [LW-1:0]    cnt_q;
  logic [LW-1:0]    cnt_d;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             empty;
  logic             in_rdy;
  logic             out_vld;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] we;
  logic [DIN-1:0]   mem [DEPTH];
  logic [DIN-1:0]   rd_data;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign in_rdy  = ~full & ~flush;
  assign out_vld = ~empty & ~flush;
  assign push    = din.valid & in_rdy;
  assign pop     = out_vld & dout.ready;

  assign din.ready  = in_rdy;
  assign dout.valid = out_vld;
  assign dout.data  = rd_data;

  decouple_ptr #(
    .DEPTH   (DEPTH),
    .RST_VAL (WR_RST)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .clr (flush),
    .ptr (wr_ptr)
  );

  decouple_ptr #(
    .DEPTH   (DEPTH),
    .RST_VAL (0)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .clr (flush),
    .ptr (rd_ptr)
  );

  // One-hot write enable for the entry addressed by the write pointer.
  always_comb begin
    we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we[i] = push && (wr_ptr == PW'(i));
    end
  end

  // Storage: only entry 0 is reset, and only when it carries the preload.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [DIN-1:0] ent_q;
    logic [DIN-1:0] ent_d;

    // Entry holds unless it is the write target.
    always_comb begin
      ent_d = we[i] ? din.data : ent_q;
    end

    if (i == 0 && INIT_VALID) begin : g_init
      // Preloaded entry register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ent_q <= INIT;
        end else begin
          ent_q <= ent_d;
        end
      end
    end else begin : g_plain
      // Plain data entry register, no reset needed.
      always_ff @(posedge clk) begin
        ent_q <= ent_d;
      end
    end

    assign mem[i] = ent_q;
  end

  // Read mux on the read pointer; explicit compare keeps odd depths safe.
  always_comb begin
    rd_data = mem[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_ptr == PW'(i)) begin
        rd_data = mem[i];
      end
    end
  end

  // Occupancy update: flush clears, simultaneous push and pop hold.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + LW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= LW'(INIT_VALID);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign level        = cnt_q;
  assign almost_full  = (cnt_q >= LW'(AFULL));
  assign almost_empty = (cnt_q <= LW'(AEMPTY));

endmodule
